uart_rx_fifo_param: RTL

//  Parametrised next-generation UART receiver: N data bits, optional parity, 1/2 stop bits.

---
 rtl/uart_rx_fifo_param_pkg.sv | 10 +
 rtl/uart_rx_fifo_param_if.sv | 16 +
 rtl/uart_rx_fifo_param_fifo.sv | 41 ++++
 rtl/uart_rx_fifo_param.sv | 113 +++++++++++
 4 files changed

// File: rtl/uart_rx_fifo_param_pkg.sv
// uart_rx_fifo_param_pkg: shared UART receiver types and baud divisor helper
package uart_pkg;
  typedef enum logic [1:0] {PAR_NONE, PAR_ODD, PAR_EVEN} parity_e;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} rx_state_e;
  function automatic int baud_div(input int clk_hz, input int baud, input int os);
    int d;
    d = (clk_hz + baud * os / 2) / (baud * os);
    return d < 1 ? 1 : d;
  endfunction
endpackage

// File: rtl/uart_rx_fifo_param_if.sv
// uart_rx_fifo_param_if: serial line, pop port and status of the UART receiver
interface uart_rx_fifo_param_if #(parameter int DATA_BITS = 8, parameter int FIFO_DEPTH = 4);
  logic rx;
  logic rd_en;
  logic err_clr;
  logic [DATA_BITS-1:0] data;
  logic data_valid;
  logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level;
  logic frame_err;
  logic parity_err;
  logic overrun_err;
  modport master (output rx, rd_en, err_clr,
                  input data, data_valid, fifo_level, frame_err, parity_err, overrun_err);
  modport slave (input rx, rd_en, err_clr,
                 output data, data_valid, fifo_level, frame_err, parity_err, overrun_err);
endinterface

// File: rtl/uart_rx_fifo_param_fifo.sv
// uart_rx_sync_fifo: show-ahead synchronous FIFO, head reads 0 when empty
module uart_rx_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic [WIDTH-1:0] din,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] count;
  logic do_push, do_pop;
  assign full = count == LW'(DEPTH);
  assign empty = count == '0;
  assign do_pop = pop && !empty;
  // a pop frees the slot a push into a full FIFO needs in the same cycle
  assign do_push = push && (!full || do_pop);
  assign level = count;
  assign head = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + LW'(do_push) - LW'(do_pop);
    end
endmodule

// File: rtl/uart_rx_fifo_param.sv
// uart_rx_fifo_param: oversampled UART receiver with majority vote and RX FIFO
module uart_rx_fifo_param
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD_RATE = 115_200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS = 8,
  parameter int PARITY = 0,
  parameter int STOP_BITS = 1,
  parameter int FIFO_DEPTH = 4
) (
  input logic clk,
  input logic rst,
  uart_rx_fifo_param_if.slave bus
);
  localparam int DIV = baud_div(CLK_HZ, BAUD_RATE, OVERSAMPLE);
  localparam int DCW = $clog2(DIV+1);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam parity_e PAR = parity_e'(PARITY);
  localparam logic [TW-1:0] T_A = TW'(OVERSAMPLE/2-1);
  localparam logic [TW-1:0] T_B = TW'(OVERSAMPLE/2);
  localparam logic [TW-1:0] T_C = TW'(OVERSAMPLE/2+1);
  localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE-1);
  rx_state_e state;
  logic sync1, sync2, rx_prev, s0, s1, stop_cnt, par_bad;
  logic [DCW-1:0] div_cnt;
  logic [TW-1:0] tick_cnt, hi_cnt;
  logic [BW-1:0] bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic tick, vote_now, v, stop_last, push, full, empty, fe_set, pe_set, ov_set;
  assign tick = div_cnt == DCW'(DIV-1);
  assign vote_now = tick && tick_cnt == T_C;
  assign v = (s0 & s1) | (s0 & sync2) | (s1 & sync2);
  assign stop_last = (STOP_BITS == 1) || stop_cnt;
  assign pe_set = state == uart_pkg::PARITY && vote_now && ((PAR == PAR_ODD) ? ~(^shreg ^ v) : (^shreg ^ v));
  assign fe_set = state == STOP && vote_now && !v;
  assign push = state == STOP && vote_now && v && stop_last && !par_bad;
  assign ov_set = push && full && !bus.rd_en;
  assign bus.data_valid = !empty;
  uart_rx_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_BITS)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(bus.rd_en), .din(shreg),
    .full(full), .empty(empty), .level(bus.fifo_level), .head(bus.data)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      rx_prev <= 1'b1;
      s0 <= 1'b1;
      s1 <= 1'b1;
      div_cnt <= '0;
      tick_cnt <= '0;
      hi_cnt <= '0;
      bit_cnt <= '0;
      stop_cnt <= 1'b0;
      par_bad <= 1'b0;
      shreg <= '0;
      bus.frame_err <= 1'b0;
      bus.parity_err <= 1'b0;
      bus.overrun_err <= 1'b0;
    end else begin
      sync1 <= bus.rx;
      sync2 <= sync1;
      rx_prev <= sync2;
      div_cnt <= tick ? '0 : div_cnt + DCW'(1);
      if (tick) tick_cnt <= tick_cnt == T_END ? '0 : tick_cnt + TW'(1);
      if (tick && tick_cnt == T_A) s0 <= sync2;
      if (tick && tick_cnt == T_B) s1 <= sync2;
      // a new error outranks a simultaneous clear
      bus.frame_err <= fe_set | (bus.frame_err & ~bus.err_clr);
      bus.parity_err <= pe_set | (bus.parity_err & ~bus.err_clr);
      bus.overrun_err <= ov_set | (bus.overrun_err & ~bus.err_clr);
      case (state)
        IDLE: if (rx_prev && !sync2) begin
          state <= START;
          div_cnt <= '0;
          tick_cnt <= '0;
          par_bad <= 1'b0;
          stop_cnt <= 1'b0;
        end
        START: if (vote_now) begin
          state <= v ? IDLE : DATA;
          bit_cnt <= '0;
        end
        DATA: if (vote_now) begin
          shreg <= {v, shreg[DATA_BITS-1:1]};
          bit_cnt <= bit_cnt + BW'(1);
          if (bit_cnt == BW'(DATA_BITS-1)) state <= PAR == PAR_NONE ? STOP : uart_pkg::PARITY;
        end
        uart_pkg::PARITY: if (vote_now) begin
          par_bad <= pe_set;
          state <= STOP;
        end
        // transitions happen at mid-bit, so the next vote lands one bit later
        STOP: if (vote_now) begin
          if (!v) begin
            state <= WAIT_HIGH;
            hi_cnt <= '0;
          end else if (stop_last) state <= IDLE;
          else stop_cnt <= 1'b1;
        end
        WAIT_HIGH: if (!sync2) hi_cnt <= '0;
          else if (tick) begin
            hi_cnt <= hi_cnt + TW'(1);
            if (hi_cnt == T_END) state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
endmodule
